// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving a single shared full-adder cell

// Single 1-bit full-adder cell; carry-out is the true majority of x, y, c.
module serial_add_fa (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic c_next
);

    assign s      = x ^ y ^ c;
    assign c_next = (x & y) | (c & (x ^ y));

endmodule

// Sequences the FA cell over WIDTH bits, LSB first, one bit per clock.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    // Counter just wide enough to index WIDTH bit positions.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             co_q,    co_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;
    logic             cnt_last;

    // The one shared FA cell always sees the current LSBs and the carry flop.
    serial_add_fa u_fa (
        .x      (a_sh_q[0]),
        .y      (b_sh_q[0]),
        .c      (carry_q),
        .s      (fa_s),
        .c_next (fa_c)
    );

    // Each new sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
    assign res_next = {fa_s, res_q[WIDTH-1:1]};
    assign cnt_last = (cnt_q == CNT_LAST);

    // State register and datapath flops; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    // Next-state and datapath update; start is honoured only in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                res_d   = res_next;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                if (cnt_last) begin
                    // Final bit: publish result; counter holds rather than wrapping.
                    sum_d   = res_next;
                    co_d    = fa_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks for serial_add_ctrl

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one start and waits for done.
    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic [W-1:0] exp_sum, input logic exp_co, input string tag);
        int k;
        int nb;
        logic [W-1:0] held;
        logic moved;
        held  = sum;
        moved = 1'b0;
        start = 1'b1; a = av; b = bv; ci = cv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; ci = ~cv;
        k  = 0;
        nb = 0;
        while (!done && k < 30) begin
            if (busy) nb++;
            if (sum !== held) moved = 1'b1;
            k++;
            @(negedge clk);
        end
        check({tag, " latency"}, k, 8);
        check({tag, " busy_cycles"}, nb, 8);
        check({tag, " sum_stable"}, moved, 0);
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " co"}, co, exp_co);
    endtask

    initial begin
        int k;
        int nb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   model;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset co", co, 0);
        rst = 1'b0;
        @(negedge clk);

        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "t1");
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2");
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3a");
        do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "t3b");

        // Second start three edges into RUN must be ignored.
        start = 1'b1; a = 8'h55; b = 8'hAA; ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0; nb = 0;
        while (!done && k < 30) begin
            if (busy) nb++;
            if (k == 2) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("t4 latency", k, 8);
        check("t4 busy_cycles", nb, 8);
        check("t4 sum", sum, 8'hFF);
        check("t4 co", co, 0);
        @(negedge clk);
        check("t4 no_requeue busy", busy, 0);

        // Start held high across DONE: back-to-back with no bubble.
        start = 1'b1; a = 8'h10; b = 8'h20; ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'h03; b = 8'h04;
        k = 0;
        while (!done && k < 30) begin
            k++;
            @(negedge clk);
        end
        check("t5 first latency", k, 8);
        check("t5 first sum", sum, 8'h30);
        @(negedge clk);
        start = 1'b0;
        check("t5 no_bubble busy", busy, 1);
        check("t5 done_low", done, 0);
        k = 1;
        while (!done && k < 30) begin
            k++;
            @(negedge clk);
        end
        check("t5 done_spacing", k, 9);
        check("t5 second sum", sum, 8'h07);
        check("t5 second co", co, 0);
        @(negedge clk);

        // Async reset mid-operation clears everything without a clock edge.
        do_add(8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1, "t6pre");
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6 rst busy", busy, 0);
        check("t6 rst done", done, 0);
        check("t6 rst sum", sum, 0);
        check("t6 rst co", co, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6 idle busy", busy, 0);
        do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t6post");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_add(ra, rb, rc, model[W-1:0], model[W], "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
